// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed 32-bit multiply/divide (shift-add / restoring), 32 cycles per op
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   ctrl_mult, ctrl_div     start pulses, accepted only in IDLE or DONE (multiply wins)
//   operand_a, operand_b    signed operands, latched at the accepting edge
//   result, exception       registered product low word / quotient and error flag
//   result_ready            one-cycle completion strobe (state DONE)
//   busy                    high while iterating (pipeline stall)
module mult_div_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrl_mult,
    input  logic        ctrl_div,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic [31:0] result,
    output logic        exception,
    output logic        result_ready,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
    state_t state, state_next;
    logic [5:0] cnt;
    logic neg, ovf, dz_pend;
    logic [63:0] acc, mcand;
    logic [31:0] mplier, rem, quo, dvsr;
    logic [31:0] mag_a, mag_b, rem_next, quo_next;
    logic [63:0] prod_step, prod_signed;
    logic [32:0] rem_sh, diff;
    logic go, dz, last;
    assign mag_a = operand_a[31] ? -operand_a : operand_a;
    assign mag_b = operand_b[31] ? -operand_b : operand_b;
    // A divide-by-zero start spends one idle cycle (dz_pend) so DONE lands one edge after acceptance.
    assign go = (state == IDLE || state == DONE) && !dz_pend && (ctrl_mult || ctrl_div);
    assign dz = go && !ctrl_mult && operand_b == 32'd0;
    assign last = cnt == 6'd31;
    assign prod_step = acc + (mplier[0] ? mcand : 64'd0);
    assign prod_signed = neg ? -prod_step : prod_step;
    assign rem_sh = {rem, quo[31]};
    assign diff = rem_sh - {1'b0, dvsr};
    assign rem_next = diff[32] ? rem_sh[31:0] : diff[31:0];
    assign quo_next = {quo[30:0], ~diff[32]};
    assign result_ready = state == DONE;
    assign busy = state == MULT || state == DIV;
    always_comb begin
        state_next = state;
        if (go)
            state_next = ctrl_mult ? MULT : (dz ? IDLE : DIV);
        else if (dz_pend || (busy && last))
            state_next = DONE;
        else if (state == DONE)
            state_next = IDLE;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt <= 6'd0;
            neg <= 1'b0;
            ovf <= 1'b0;
            dz_pend <= 1'b0;
            acc <= 64'd0;
            mcand <= 64'd0;
            mplier <= 32'd0;
            rem <= 32'd0;
            quo <= 32'd0;
            dvsr <= 32'd0;
            result <= 32'd0;
            exception <= 1'b0;
        end else begin
            state <= state_next;
            dz_pend <= dz;
            if (go) begin
                cnt <= 6'd0;
                neg <= operand_a[31] ^ operand_b[31];
                ovf <= operand_a == 32'h8000_0000 && operand_b == 32'hFFFF_FFFF;
                acc <= 64'd0;
                mcand <= {32'd0, mag_a};
                mplier <= mag_b;
                rem <= 32'd0;
                quo <= mag_a;
                dvsr <= mag_b;
            end else if (dz_pend) begin
                result <= 32'd0;
                exception <= 1'b1;
            end else if (state == MULT) begin
                cnt <= cnt + 6'd1;
                acc <= prod_step;
                mcand <= mcand << 1;
                mplier <= mplier >> 1;
                if (last) begin
                    result <= prod_signed[31:0];
                    exception <= ~(&prod_signed[63:31] | ~|prod_signed[63:31]);
                end
            end else if (state == DIV) begin
                cnt <= cnt + 6'd1;
                rem <= rem_next;
                quo <= quo_next;
                if (last) begin
                    result <= neg ? -quo_next : quo_next;
                    exception <= ovf;
                end
            end
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: table, corner-sequence and random checks of mult_div_unit against an arithmetic model
module tb_mult_div_unit;
    logic clock = 0, reset = 1, ctrl_mult = 0, ctrl_div = 0;
    logic [31:0] operand_a = 0, operand_b = 0;
    logic [31:0] result;
    logic exception, result_ready, busy;
    int tests = 0, fails = 0;

    mult_div_unit dut (
        .clock(clock), .reset(reset), .ctrl_mult(ctrl_mult), .ctrl_div(ctrl_div),
        .operand_a(operand_a), .operand_b(operand_b), .result(result),
        .exception(exception), .result_ready(result_ready), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic m;
        logic d;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic e;
        int lat;
    } vec_t;
    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [32:0] model(input logic m, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int q;
        if (m) begin
            p = longint'($signed(a)) * longint'($signed(b));
            return {p != longint'($signed(p[31:0])), p[31:0]};
        end
        if (b == 32'd0) return {1'b1, 32'd0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 32'h8000_0000};
        q = int'(a) / int'(b);
        return {1'b0, q};
    endfunction

    // called at a negedge; start is held across exactly one rising edge, then operands are scrambled
    task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        ctrl_mult = m;
        ctrl_div = d;
        operand_a = a;
        operand_b = b;
        @(posedge clock);
        #1;
        ctrl_mult = 0;
        ctrl_div = 0;
        operand_a = $urandom;
        operand_b = $urandom;
    endtask

    // l = rising edges since the accepting edge when result_ready is seen (bounded)
    task automatic wait_ready(output int l, output logic ball, output logic bany);
        l = 0;
        ball = 1;
        bany = 0;
        @(negedge clock);
        while (!result_ready && l < 40) begin
            ball &= busy;
            bany |= busy;
            l++;
            @(negedge clock);
        end
    endtask

    initial begin
        int lat, n;
        logic ball, bany;
        logic [32:0] exp;
        logic [31:0] a, b;
        logic m;
        vecs[0]  = '{1, 0, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 0, 32};
        vecs[1]  = '{1, 0, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1, 32};
        vecs[2]  = '{0, 1, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 0, 32};
        vecs[3]  = '{0, 1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, 32};
        vecs[4]  = '{0, 1, 32'd5,          32'd0,         32'h0000_0000, 1, 1};
        vecs[5]  = '{1, 1, 32'd3,          32'd4,         32'd12,        0, 32};
        vecs[6]  = '{1, 0, 32'h8000_0000,  32'd1,         32'h8000_0000, 0, 32};
        vecs[7]  = '{1, 0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, 32};
        vecs[8]  = '{0, 1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 0, 32};
        vecs[9]  = '{0, 1, 32'd0,          32'd5,         32'd0,         0, 32};
        vecs[10] = '{0, 1, 32'h8000_0000,  32'd1,         32'h8000_0000, 0, 32};

        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("reset result", result, 0);
        chk("reset exception", {31'd0, exception}, 0);
        chk("reset ready", {31'd0, result_ready}, 0);
        chk("reset busy", {31'd0, busy}, 0);
        reset = 0;
        @(negedge clock);

        foreach (vecs[i]) begin
            start_op(vecs[i].m, vecs[i].d, vecs[i].a, vecs[i].b);
            wait_ready(lat, ball, bany);
            chk($sformatf("vec%0d result", i), result, vecs[i].r);
            chk($sformatf("vec%0d exception", i), {31'd0, exception}, {31'd0, vecs[i].e});
            chk($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d busy", i), {31'd0, vecs[i].lat == 1 ? bany : ball}, {31'd0, vecs[i].lat != 1});
            chk($sformatf("vec%0d busy at done", i), {31'd0, busy}, 0);
            @(negedge clock);
            chk($sformatf("vec%0d ready pulse", i), {31'd0, result_ready}, 0);
        end

        start_op(1, 0, 32'd100, 32'd3);
        repeat (10) @(negedge clock);
        ctrl_mult = 1;
        ctrl_div = 1;
        operand_a = 32'd5;
        operand_b = 32'd0;
        @(posedge clock);
        #1;
        ctrl_mult = 0;
        ctrl_div = 0;
        wait_ready(lat, ball, bany);
        chk("ignored start result", result, 32'd300);
        chk("ignored start exception", {31'd0, exception}, 0);
        chk("ignored start latency", lat + 10, 32);
        repeat (5) @(negedge clock);
        chk("result hold", result, 32'd300);
        chk("hold ready low", {31'd0, result_ready}, 0);

        start_op(1, 0, 32'hFFFF_FFFD, 32'd11);
        wait_ready(lat, ball, bany);
        chk("b2b mult result", result, 32'hFFFF_FFDF);
        start_op(0, 1, 32'd100, 32'hFFFF_FFF9);
        wait_ready(lat, ball, bany);
        chk("b2b div result", result, 32'hFFFF_FFF2);
        chk("b2b ready spacing", lat + 1, 33);
        @(negedge clock);

        start_op(1, 0, 32'd7, 32'd9);
        repeat (15) @(negedge clock);
        reset = 1;
        @(posedge clock);
        @(negedge clock);
        reset = 0;
        chk("midreset result", result, 0);
        chk("midreset exception", {31'd0, exception}, 0);
        chk("midreset busy", {31'd0, busy}, 0);
        chk("midreset ready", {31'd0, result_ready}, 0);
        n = 0;
        repeat (40) begin
            @(negedge clock);
            n += int'(result_ready);
        end
        chk("midreset no pulse", n, 0);

        repeat (40) begin
            m = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 1) == 1) a = $urandom_range(0, 2000) - 1000;
            if ($urandom_range(0, 1) == 1) b = $urandom_range(0, 60) - 30;
            if (!m && $urandom_range(0, 7) == 0) b = 0;
            exp = model(m, a, b);
            start_op(m, !m, a, b);
            wait_ready(lat, ball, bany);
            chk($sformatf("rand %s %h %h result", m ? "mul" : "div", a, b), result, exp[31:0]);
            chk($sformatf("rand %s %h %h exception", m ? "mul" : "div", a, b), {31'd0, exception}, {31'd0, exp[32]});
            chk("rand latency", lat, (!m && b == 0) ? 1 : 32);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
